// File: rtl/enc8b10b_pkg.sv
// 8b/10b code tables and helpers shared by the lane encoder.
package enc8b10b_pkg;

  // 5b/6b codes (abcdei, a = MSB) in their RD- form, indexed by EDCBA.
  localparam logic [5:0] ENC_5B6B [32] = '{
    6'b100111, 6'b011101, 6'b101101, 6'b110001,
    6'b110101, 6'b101001, 6'b011001, 6'b111000,
    6'b111001, 6'b100101, 6'b010101, 6'b110100,
    6'b001101, 6'b101100, 6'b011100, 6'b010111,
    6'b011011, 6'b100011, 6'b010011, 6'b110010,
    6'b001011, 6'b101010, 6'b011010, 6'b111010,
    6'b110011, 6'b100110, 6'b010110, 6'b110110,
    6'b001110, 6'b101110, 6'b011110, 6'b101011
  };

  // Entries whose RD+ code is the complement of the RD- code
  // (all unbalanced codes plus the balanced D.7 pair 111000/000111).
  localparam logic [31:0] ENC_5B6B_COMP = 32'hE981_8197;

  localparam logic [5:0] K28_6B = 6'b001111;

  // 3b/4b data codes (fghj, f = MSB) in RD- form, indexed by HGF; y=7 is P7.
  localparam logic [3:0] ENC_3B4B [8] = '{
    4'b1011, 4'b1001, 4'b0101, 4'b1100,
    4'b1101, 4'b1010, 4'b0110, 4'b1110
  };

  // Data entries complemented at RD+: y = 0, 3, 4, 7.
  localparam logic [7:0] ENC_3B4B_COMP = 8'h99;

  // K28.y 3b/4b codes in RD- form; every entry is complemented at RD+.
  localparam logic [3:0] ENC_K28_3B4B [8] = '{
    4'b1011, 4'b0110, 4'b1010, 4'b1100,
    4'b1101, 4'b0101, 4'b1001, 4'b0111
  };

  // Alternate x.7 code (RD- form; RD+ form is 1000).
  localparam logic [3:0] A7_4B = 4'b0111;

  // D.x.7 values of x that take A7 at RD- (17, 18, 20) and at RD+ (11, 13, 14).
  localparam logic [31:0] A7_RDM_SET = 32'h0016_0000;
  localparam logic [31:0] A7_RDP_SET = 32'h0000_6800;

  // Legal control characters: K28.0-K28.7, K23.7, K27.7, K29.7, K30.7.
  localparam int unsigned K_LEGAL_N = 12;
  localparam logic [7:0] K_LEGAL [12] = '{
    8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC,
    8'hF7, 8'hFB, 8'hFD, 8'hFE
  };

  // Ones minus zeros over the low 'width' bits of a code (6, 4 or 10).
  function automatic int code_disparity(input logic [9:0] code, input int unsigned width);
    int ones;
    ones = 0;
    for (int unsigned i = 0; i < width; i++) begin
      if (code[i]) ones++;
    end
    return 2 * ones - int'(width);
  endfunction

endpackage

// File: rtl/enc8b10b_sym.sv
// Combinational single-symbol 8b/10b encoder (5b/6b then 3b/4b).
module enc8b10b_sym
  import enc8b10b_pkg::*;
(
  input  logic [7:0] data,
  input  logic       k,
  input  logic       rd_in,
  output logic [9:0] code,
  output logic       rd_out,
  output logic       k_illegal
);

  logic [4:0] x;
  logic [2:0] y;
  logic       is_k_code;
  logic       k_use;
  logic       k28;
  logic       comp6;
  logic       comp4;
  logic       use_a7;
  logic       rd_mid;
  logic [5:0] c6_neg;
  logic [5:0] c6;
  logic [3:0] c4_neg;
  logic [3:0] c4;

  // Classify the symbol, then pick each sub-block code for the RD it sees.
  always_comb begin
    x = data[4:0];
    y = data[7:5];

    is_k_code = 1'b0;
    for (int unsigned n = 0; n < K_LEGAL_N; n++) begin
      if (data == K_LEGAL[n]) is_k_code = 1'b1;
    end
    // An illegal K falls back to the plain D encoding of the same byte.
    k_use     = k && is_k_code;
    k_illegal = k && !is_k_code;
    k28       = k_use && (x == 5'd28);

    if (k28) begin
      c6_neg = K28_6B;
      comp6  = 1'b1;
    end else begin
      c6_neg = ENC_5B6B[x];
      comp6  = ENC_5B6B_COMP[x];
    end
    c6     = (rd_in && comp6) ? ~c6_neg : c6_neg;
    rd_mid = (code_disparity({4'b0000, c6}, 6) != 0) ? !rd_in : rd_in;

    use_a7 = (y == 3'd7) &&
             (k_use || (!rd_mid && A7_RDM_SET[x]) || (rd_mid && A7_RDP_SET[x]));
    if (use_a7) begin
      c4_neg = A7_4B;
      comp4  = 1'b1;
    end else if (k28) begin
      c4_neg = ENC_K28_3B4B[y];
      comp4  = 1'b1;
    end else begin
      c4_neg = ENC_3B4B[y];
      comp4  = ENC_3B4B_COMP[y];
    end
    c4     = (rd_mid && comp4) ? ~c4_neg : c4_neg;
    rd_out = (code_disparity({6'b000000, c4}, 4) != 0) ? !rd_mid : rd_mid;

    code = {c6, c4};
  end

endmodule

// File: rtl/enc8b10b_lanes.sv
// Multi-lane 8b/10b encoder with valid/ready handshake and registered output.
module enc8b10b_lanes
  import enc8b10b_pkg::*;
#(
  parameter int unsigned LANES   = 2,
  parameter bit          CHAIN   = 1'b0,
  parameter bit          RD_INIT = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [8*LANES-1:0]    s_data,
  input  logic [LANES-1:0]      s_k,
  input  logic                  rd_clear,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [10*LANES-1:0]   m_data,
  output logic [LANES-1:0]      m_rd,
  output logic [LANES-1:0]      k_err
);

  logic                 accept;
  logic [LANES-1:0]     rd_out;
  logic [LANES-1:0]     k_illegal;
  logic [10*LANES-1:0]  code;

  logic                 m_valid_q, m_valid_d;
  logic [10*LANES-1:0]  m_data_q, m_data_d;
  logic [LANES-1:0]     m_rd_q, m_rd_d;
  logic [LANES-1:0]     k_err_q, k_err_d;

  assign s_ready = !m_valid_q || m_ready;
  assign accept  = s_valid && s_ready;

  if (CHAIN) begin : g_chain
    logic rd_q, rd_d, rd_start;

    // rd_clear overrides the stored RD before this cycle's symbols are encoded.
    assign rd_start = rd_clear ? RD_INIT : rd_q;

    // Stream RD follows the last lane on accept, otherwise holds (or clears).
    always_comb begin
      rd_d = rd_start;
      if (accept) rd_d = rd_out[LANES-1];
    end

    // Stream RD register.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rd_q <= RD_INIT;
      else        rd_q <= rd_d;
    end

    // Lane-local RD wires keep the ripple chain free of vector self-loops.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
      logic lane_rd_in, lane_rd_out;
      if (i == 0) begin : g_head
        assign lane_rd_in = rd_start;
      end else begin : g_tail
        assign lane_rd_in = g_lane[i-1].lane_rd_out;
      end
      enc8b10b_sym u_sym (
        .data      (s_data[8*i +: 8]),
        .k         (s_k[i]),
        .rd_in     (lane_rd_in),
        .code      (code[10*i +: 10]),
        .rd_out    (lane_rd_out),
        .k_illegal (k_illegal[i])
      );
      assign rd_out[i] = lane_rd_out;
    end
  end else begin : g_indep
    logic [LANES-1:0] rd_q, rd_d, rd_start;

    assign rd_start = rd_clear ? {LANES{RD_INIT}} : rd_q;

    // Per-lane RD follows its own lane on accept.
    always_comb begin
      rd_d = rd_start;
      if (accept) rd_d = rd_out;
    end

    // Per-lane RD registers.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rd_q <= {LANES{RD_INIT}};
      else        rd_q <= rd_d;
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
      enc8b10b_sym u_sym (
        .data      (s_data[8*i +: 8]),
        .k         (s_k[i]),
        .rd_in     (rd_start[i]),
        .code      (code[10*i +: 10]),
        .rd_out    (rd_out[i]),
        .k_illegal (k_illegal[i])
      );
    end
  end

  // Output stage: load on accept, hold under backpressure, drop valid once taken.
  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_rd_d    = m_rd_q;
    k_err_d   = k_err_q;
    if (rd_clear) k_err_d = '0;
    if (accept) begin
      m_valid_d = 1'b1;
      m_data_d  = code;
      m_rd_d    = rd_out;
      k_err_d   = k_err_d | k_illegal;
    end else if (m_ready) begin
      m_valid_d = 1'b0;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_rd_q    <= {LANES{RD_INIT}};
      k_err_q   <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_rd_q    <= m_rd_d;
      k_err_q   <= k_err_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_rd    = m_rd_q;
  assign k_err   = k_err_q;

endmodule

// File: tb/tb_enc8b10b_lanes.sv
// Bench for enc8b10b_lanes: one independent-lane and one chained 2-lane instance
// driven with the same stimulus, checked against a running-disparity model.
module tb_enc8b10b_lanes;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid, rd_clear, m_ready;
  logic [15:0] s_data;
  logic [1:0]  s_k;

  logic        i_s_ready, i_m_valid, c_s_ready, c_m_valid;
  logic [19:0] i_m_data, c_m_data;
  logic [1:0]  i_m_rd, i_k_err, c_m_rd, c_k_err;

  int total = 0;
  int bad   = 0;

  // Model state
  bit          e_valid;
  logic [19:0] e_i_data, e_c_data;
  logic [1:0]  e_i_rd, e_c_rd, e_i_kerr, e_c_kerr;
  logic [1:0]  mi_rd;
  bit          mc_rd;

  localparam logic [5:0] T6 [32] = '{
    6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
    6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
    6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
    6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011
  };
  localparam logic [3:0] D4 [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
  localparam logic [3:0] K4 [8] = '{4'b1011, 4'b0110, 4'b1010, 4'b1100, 4'b1101, 4'b0101, 4'b1001, 4'b0111};
  localparam logic [7:0] KL [12] = '{8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC,
                                     8'hF7, 8'hFB, 8'hFD, 8'hFE};

  enc8b10b_lanes #(.LANES(2), .CHAIN(0), .RD_INIT(0)) u_ind (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(i_s_ready), .s_data(s_data),
    .s_k(s_k), .rd_clear(rd_clear), .m_valid(i_m_valid), .m_ready(m_ready),
    .m_data(i_m_data), .m_rd(i_m_rd), .k_err(i_k_err)
  );

  enc8b10b_lanes #(.LANES(2), .CHAIN(1), .RD_INIT(0)) u_chn (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(c_s_ready), .s_data(s_data),
    .s_k(s_k), .rd_clear(rd_clear), .m_valid(c_m_valid), .m_ready(m_ready),
    .m_data(c_m_data), .m_rd(c_m_rd), .k_err(c_k_err)
  );

  always #5 clk = ~clk;

  function automatic int ones(input logic [9:0] v, input int n);
    int c;
    c = 0;
    for (int b = 0; b < n; b++) if (v[b]) c++;
    return c;
  endfunction

  // Reference encoder: the tables hold RD- forms; the RD+ form mirrors any
  // unbalanced block and the balanced 111000 / 1100 / K28 pairs. RD afterwards
  // is the sign of the last unbalanced sub-block.
  function automatic void ref_enc(input logic [7:0] b, input bit k, input bit rd_in,
                                  output logic [9:0] code, output bit rd_o, output bit ill);
    int x, y;
    bit k28, kl, rd;
    logic [5:0] s;
    logic [3:0] f;
    x   = int'(b[4:0]);
    y   = int'(b[7:5]);
    k28 = k && (x == 28);
    kl  = k28 || (k && y == 7 && (x == 23 || x == 27 || x == 29 || x == 30));
    ill = k && !kl;
    s = k28 ? 6'b001111 : T6[x];
    if (rd_in && (ones({4'b0, s}, 6) != 3 || s == 6'b111000)) s = ~s;
    rd = rd_in;
    if (ones({4'b0, s}, 6) != 3) rd = (ones({4'b0, s}, 6) > 3);
    if (y == 7 && (kl || (!rd && (x == 17 || x == 18 || x == 20)) ||
                   (rd && (x == 11 || x == 13 || x == 14))))
      f = 4'b0111;
    else
      f = k28 ? K4[y] : D4[y];
    if (rd && (ones({6'b0, f}, 4) != 2 || f == 4'b1100 || k28)) f = ~f;
    if (ones({6'b0, f}, 4) != 2) rd = (ones({6'b0, f}, 4) > 2);
    code = {s, f};
    rd_o = rd;
  endfunction

  task automatic model_reset();
    e_valid  = 1'b0;
    e_i_data = '0; e_c_data = '0;
    e_i_rd   = '0; e_c_rd   = '0;
    e_i_kerr = '0; e_c_kerr = '0;
    mi_rd    = '0; mc_rd    = 1'b0;
  endtask

  // Advance one clock with the currently driven inputs and update the model.
  task automatic step();
    bit acc, r0, r1, il0, il1;
    logic [9:0] c0, c1;
    acc = s_valid && (!e_valid || m_ready);
    @(posedge clk);
    if (rd_clear) begin
      mi_rd = '0; mc_rd = 1'b0; e_i_kerr = '0; e_c_kerr = '0;
    end
    if (acc) begin
      ref_enc(s_data[7:0],  s_k[0], mi_rd[0], c0, r0, il0);
      ref_enc(s_data[15:8], s_k[1], mi_rd[1], c1, r1, il1);
      mi_rd = {r1, r0}; e_i_data = {c1, c0}; e_i_rd = {r1, r0};
      e_i_kerr = e_i_kerr | {il1, il0};
      ref_enc(s_data[7:0],  s_k[0], mc_rd, c0, r0, il0);
      ref_enc(s_data[15:8], s_k[1], r0,    c1, r1, il1);
      mc_rd = r1; e_c_data = {c1, c0}; e_c_rd = {r1, r0};
      e_c_kerr = e_c_kerr | {il1, il0};
      e_valid = 1'b1;
    end else if (m_ready) begin
      e_valid = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    total++;
    if ({i_m_valid, i_m_data, i_m_rd, i_k_err, c_m_valid, c_m_data, c_m_rd, c_k_err} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got ind=%b_%h_%b_%b chn=%b_%h_%b_%b req all zero",
               i_m_valid, i_m_data, i_m_rd, i_k_err, c_m_valid, c_m_data, c_m_rd, c_k_err);
    end
    total++;
    if (i_s_ready !== 1'b1 || c_s_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_s_ready got ind=%b chn=%b req 1", i_s_ready, c_s_ready);
    end
  endtask

  task automatic test_known_vectors();
    m_ready = 1'b1; s_valid = 1'b1; s_k = 2'b00; s_data = 16'h0000;
    for (int n = 0; n < 2; n++) begin
      step();
      total++;
      if (i_m_data[9:0] !== 10'b1001110100 || i_m_rd[0] !== 1'b0 || i_m_valid !== 1'b1) begin
        bad++;
        $display("FAIL d0_0_%0d got code=%b rd=%b v=%b req code=1001110100 rd=0 v=1",
                 n, i_m_data[9:0], i_m_rd[0], i_m_valid);
      end
    end
    s_data = 16'hBCBC; s_k = 2'b11;
    step();
    total++;
    if (i_m_data[9:0] !== 10'b0011111010 || i_m_rd !== 2'b11) begin
      bad++;
      $display("FAIL k28_5_rdm got code=%b m_rd=%b req code=0011111010 m_rd=11", i_m_data[9:0], i_m_rd);
    end
    total++;
    if (c_m_data !== {10'b1100000101, 10'b0011111010} || c_m_rd[0] !== 1'b1 || c_m_rd[1] !== 1'b0) begin
      bad++;
      $display("FAIL k28_5_chain got lane1=%b lane0=%b m_rd=%b req lane1=1100000101 lane0=0011111010 rd lane0=1 lane1=0",
               c_m_data[19:10], c_m_data[9:0], c_m_rd);
    end
    step();
    total++;
    if (i_m_data[9:0] !== 10'b1100000101 || i_m_rd[0] !== 1'b0) begin
      bad++;
      $display("FAIL k28_5_rdp got code=%b rd=%b req code=1100000101 rd=0", i_m_data[9:0], i_m_rd[0]);
    end
    s_data = 16'hF1F1; s_k = 2'b00;
    step();
    total++;
    if (i_m_data[9:0] !== 10'b1000110111 || i_m_rd[0] !== 1'b1) begin
      bad++;
      $display("FAIL d17_7_a7 got code=%b rd=%b req code=1000110111 rd=1", i_m_data[9:0], i_m_rd[0]);
    end
    s_data = 16'hB5B5;
    step();
    total++;
    if (i_m_data[9:0] !== 10'b1010101010 || i_m_rd[0] !== 1'b1) begin
      bad++;
      $display("FAIL d21_5_neutral got code=%b rd=%b req code=1010101010 rd=1", i_m_data[9:0], i_m_rd[0]);
    end
    total++;
    if ({c_m_valid, c_m_data, c_m_rd} !== {e_valid, e_c_data, e_c_rd}) begin
      bad++;
      $display("FAIL chain_vectors got %b_%h_%b req %b_%h_%b",
               c_m_valid, c_m_data, c_m_rd, e_valid, e_c_data, e_c_rd);
    end
  endtask

  task automatic test_illegal_k();
    // lane 0 sits at RD+ after D.21.5, so D.0.0 comes out in its RD+ form
    s_valid = 1'b1; s_data = 16'h0000; s_k = 2'b01;
    step();
    total++;
    if (i_m_data[9:0] !== 10'b0110001011 || i_k_err !== 2'b01) begin
      bad++;
      $display("FAIL illegal_k got code=%b k_err=%b req code=0110001011 k_err=01", i_m_data[9:0], i_k_err);
    end
    s_valid = 1'b0; s_k = 2'b00;
    step();
    total++;
    if (i_k_err !== 2'b01 || c_k_err !== e_c_kerr) begin
      bad++;
      $display("FAIL k_err_sticky got ind=%b chn=%b req ind=01 chn=%b", i_k_err, c_k_err, e_c_kerr);
    end
    rd_clear = 1'b1; s_valid = 1'b1; s_data = 16'h00BC; s_k = 2'b01;
    step();
    rd_clear = 1'b0;
    total++;
    if (i_m_data[9:0] !== 10'b0011111010 || i_k_err !== 2'b00 || c_k_err !== 2'b00) begin
      bad++;
      $display("FAIL clear_with_accept got code=%b k_err ind=%b chn=%b req code=0011111010 k_err=00",
               i_m_data[9:0], i_k_err, c_k_err);
    end
  endtask

  task automatic test_rd_clear_idle();
    // lane 0 is at RD+ here; a clear with no accept must still return it to RD-
    rd_clear = 1'b1; s_valid = 1'b0;
    step();
    rd_clear = 1'b0; s_valid = 1'b1; s_data = 16'hBCBC; s_k = 2'b11;
    step();
    total++;
    if (i_m_data[9:0] !== 10'b0011111010 || c_m_data[9:0] !== 10'b0011111010) begin
      bad++;
      $display("FAIL clear_idle got ind=%b chn=%b req 0011111010", i_m_data[9:0], c_m_data[9:0]);
    end
  endtask

  task automatic test_backpressure();
    logic [19:0] held_i, held_c;
    s_valid = 1'b1; s_k = 2'b00; m_ready = 1'b1; s_data = 16'($urandom);
    step();
    held_i = i_m_data; held_c = c_m_data;
    m_ready = 1'b0;
    for (int n = 0; n < 3; n++) begin
      s_data = 16'($urandom);
      #1;
      total++;
      if (i_s_ready !== 1'b0 || c_s_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_s_ready[%0d] got ind=%b chn=%b req 0", n, i_s_ready, c_s_ready);
      end
      step();
      total++;
      if (i_m_data !== held_i || c_m_data !== held_c || i_m_valid !== 1'b1 || c_m_valid !== 1'b1) begin
        bad++;
        $display("FAIL bp_hold[%0d] got ind=%h chn=%h v=%b%b req ind=%h chn=%h v=11",
                 n, i_m_data, c_m_data, i_m_valid, c_m_valid, held_i, held_c);
      end
    end
    m_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      s_data = 16'($urandom);
      step();
      total++;
      if ({i_m_valid, i_m_data, i_m_rd, c_m_valid, c_m_data, c_m_rd} !==
          {e_valid, e_i_data, e_i_rd, e_valid, e_c_data, e_c_rd}) begin
        bad++;
        $display("FAIL bp_release[%0d] got ind=%b_%h_%b chn=%b_%h_%b req ind=%b_%h_%b chn=%h_%b",
                 n, i_m_valid, i_m_data, i_m_rd, c_m_valid, c_m_data, c_m_rd,
                 e_valid, e_i_data, e_i_rd, e_c_data, e_c_rd);
      end
    end
  endtask

  task automatic test_random();
    int r;
    for (int n = 0; n < 400; n++) begin
      s_valid  = ($urandom_range(0, 3) != 0);
      m_ready  = ($urandom_range(0, 3) != 0);
      rd_clear = ($urandom_range(0, 31) == 0);
      for (int l = 0; l < 2; l++) begin
        r = int'($urandom_range(0, 7));
        if (r == 0) begin
          s_k[l] = 1'b1; s_data[8*l +: 8] = KL[$urandom_range(0, 11)];
        end else begin
          s_k[l] = (r == 1); s_data[8*l +: 8] = 8'($urandom);
        end
      end
      #1;
      total++;
      if (i_s_ready !== (!e_valid || m_ready) || c_s_ready !== (!e_valid || m_ready)) begin
        bad++;
        $display("FAIL rand_s_ready[%0d] got ind=%b chn=%b req %b", n, i_s_ready, c_s_ready, !e_valid || m_ready);
      end
      step();
      total++;
      if ({i_m_valid, i_m_data, i_m_rd, i_k_err} !== {e_valid, e_i_data, e_i_rd, e_i_kerr}) begin
        bad++;
        $display("FAIL rand_ind[%0d] got %b_%h_%b_%b req %b_%h_%b_%b", n,
                 i_m_valid, i_m_data, i_m_rd, i_k_err, e_valid, e_i_data, e_i_rd, e_i_kerr);
      end
      total++;
      if ({c_m_valid, c_m_data, c_m_rd, c_k_err} !== {e_valid, e_c_data, e_c_rd, e_c_kerr}) begin
        bad++;
        $display("FAIL rand_chain[%0d] got %b_%h_%b_%b req %b_%h_%b_%b", n,
                 c_m_valid, c_m_data, c_m_rd, c_k_err, e_valid, e_c_data, e_c_rd, e_c_kerr);
      end
    end
    rd_clear = 1'b0;
  endtask

  task automatic test_reset_midstream();
    s_valid = 1'b1; m_ready = 1'b0; s_k = 2'b00; s_data = 16'h1234;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    total++;
    if (i_m_valid !== 1'b0 || c_m_valid !== 1'b0 || i_m_data !== '0 || c_m_data !== '0) begin
      bad++;
      $display("FAIL reset_midstream got v=%b%b ind=%h chn=%h req v=00 data=0",
               i_m_valid, c_m_valid, i_m_data, c_m_data);
    end
    s_valid = 1'b0; m_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; s_valid = 1'b0; rd_clear = 1'b0; m_ready = 1'b1;
    s_data = '0; s_k = '0;
    model_reset();
    #12;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_known_vectors();
    test_illegal_k();
    test_rd_clear_idle();
    test_backpressure();
    test_random();
    test_reset_midstream();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
